// File: rtl/key_debouncer.sv
// Push-button front end: synchronises four active-low keys, debounces them and emits
// one-cycle press pulses with optional auto-repeat. ANY_PRESS is a clock enable, never a clock.
module key_debouncer #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic       CLK,
    input  logic       CLR,
    input  logic [3:0] KEY,
    output logic [3:0] PRESSED,
    output logic [3:0] PRESS,
    output logic       ANY_PRESS,
    output logic [7:0] key_state
);

    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int CW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TW   = $clog2(RMAX + 1);

    localparam logic [CW-1:0] CNT_LAST    = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] DELAY_LAST  = TW'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
    localparam logic [TW-1:0] PERIOD_LAST = TW'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        RELEASED  = 2'd0,
        HOLD_WAIT = 2'd1,
        REPEATING = 2'd2
    } key_state_t;

    logic [3:0]    s1, s2;
    logic [3:0]    pressed_nx, press_nx;
    logic [CW-1:0] cnt [4];
    logic [CW-1:0] cnt_nx [4];
    logic [TW-1:0] timer [4];
    logic [TW-1:0] timer_nx [4];
    key_state_t    state [4];
    key_state_t    state_nx [4];

    always_ff @(posedge CLK) begin
        if (CLR) begin
            s1      <= 4'hF;
            s2      <= 4'hF;
            PRESSED <= 4'h0;
            PRESS   <= 4'h0;
            for (int i = 0; i < 4; i++) begin
                cnt[i]   <= '0;
                timer[i] <= '0;
                state[i] <= RELEASED;
            end
        end else begin
            s1      <= KEY;
            s2      <= s1;
            PRESSED <= pressed_nx;
            PRESS   <= press_nx;
            for (int i = 0; i < 4; i++) begin
                cnt[i]   <= cnt_nx[i];
                timer[i] <= timer_nx[i];
                state[i] <= state_nx[i];
            end
        end
    end

    always_comb begin
        pressed_nx = PRESSED;
        press_nx   = 4'h0;
        for (int i = 0; i < 4; i++) begin
            cnt_nx[i]   = '0;
            timer_nx[i] = timer[i];
            state_nx[i] = state[i];

            // Any agreeing cycle leaves cnt_nx at zero, which is what rejects bounces.
            if (~s2[i] != PRESSED[i]) begin
                if (cnt[i] == CNT_LAST) begin
                    pressed_nx[i] = ~PRESSED[i];
                end else begin
                    cnt_nx[i] = cnt[i] + 1'b1;
                end
            end

            if (PRESSED[i] && !pressed_nx[i]) begin
                state_nx[i] = RELEASED;
                timer_nx[i] = '0;
            end else begin
                case (state[i])
                    RELEASED: begin
                        if (!PRESSED[i] && pressed_nx[i]) begin
                            state_nx[i] = HOLD_WAIT;
                            press_nx[i] = 1'b1;
                            timer_nx[i] = '0;
                        end
                    end
                    HOLD_WAIT: begin
                        // A zero delay parks the key here: one pulse per press, no repeat.
                        if (REPEAT_DELAY != 0) begin
                            if (timer[i] == DELAY_LAST) begin
                                state_nx[i] = REPEATING;
                                press_nx[i] = 1'b1;
                                timer_nx[i] = '0;
                            end else begin
                                timer_nx[i] = timer[i] + 1'b1;
                            end
                        end
                    end
                    REPEATING: begin
                        if (timer[i] == PERIOD_LAST) begin
                            press_nx[i] = 1'b1;
                            timer_nx[i] = '0;
                        end else begin
                            timer_nx[i] = timer[i] + 1'b1;
                        end
                    end
                    default: begin
                        state_nx[i] = RELEASED;
                        timer_nx[i] = '0;
                    end
                endcase
            end
        end
    end

    assign ANY_PRESS = |PRESS;
    assign key_state = {state[3], state[2], state[1], state[0]};

endmodule

// File: tb/tb_key_debouncer.sv
// Bench for key_debouncer: expected press pulses are queued as {mask, edge} and matched
// against PRESS/ANY_PRESS every cycle; a second instance covers the no-repeat build.
module tb_key_debouncer;

    logic       clk;
    logic       clr;
    logic [3:0] key_a, key_b;
    logic [3:0] pressed_a, press_a, pressed_b, press_b;
    logic       any_a, any_b;
    logic [7:0] state_a, state_b;

    int n_tests = 0;
    int n_fail  = 0;
    logic [15:0] exp_q[$];

    key_debouncer #(.DEBOUNCE_CYCLES(4), .REPEAT_DELAY(8), .REPEAT_PERIOD(3)) u_dut (
        .CLK(clk), .CLR(clr), .KEY(key_a),
        .PRESSED(pressed_a), .PRESS(press_a), .ANY_PRESS(any_a), .key_state(state_a)
    );

    key_debouncer #(.DEBOUNCE_CYCLES(4), .REPEAT_DELAY(0), .REPEAT_PERIOD(3)) u_dut_nr (
        .CLK(clk), .CLR(clr), .KEY(key_b),
        .PRESSED(pressed_b), .PRESS(press_b), .ANY_PRESS(any_b), .key_state(state_b)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        key_a = 4'hF;
        key_b = 4'hF;
        clr   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        clr = 1'b0;
        exp_q.delete();
    endtask

    // pop the expected pulse mask for relative edge e (0 if none is due)
    task automatic sb_pop(input int e, output logic [3:0] m);
        logic [15:0] head;
        m = 4'h0;
        if (exp_q.size() > 0) begin
            head = exp_q[0];
            if (head[11:0] == 12'(e)) begin
                m = head[15:12];
                void'(exp_q.pop_front());
            end
        end
    endtask

    task automatic sb_push(input logic [3:0] m, input int e);
        exp_q.push_back({m, 12'(e)});
    endtask

    task automatic test_reset();
        key_a = 4'h0;
        key_b = 4'h0;
        clr   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (pressed_a !== 4'h0 || press_a !== 4'h0 || any_a !== 1'b0 || state_a !== 8'h0) begin
            n_fail++;
            $display("FAIL reset_a pressed=%b press=%b any=%b state=%h required 0", pressed_a, press_a, any_a, state_a);
        end
        n_tests++;
        if (pressed_b !== 4'h0 || press_b !== 4'h0 || any_b !== 1'b0 || state_b !== 8'h0) begin
            n_fail++;
            $display("FAIL reset_b pressed=%b press=%b any=%b state=%h required 0", pressed_b, press_b, any_b, state_b);
        end
        do_reset();
    endtask

    task automatic test_single_press();
        logic [3:0] m;
        do_reset();
        sb_push(4'b0001, 5);
        for (int e = 0; e < 16; e++) begin
            key_a = (e < 6) ? 4'b1110 : 4'b1111;
            @(posedge clk);
            #1;
            sb_pop(e, m);
            n_tests++;
            if (press_a !== m || any_a !== (|m)) begin
                n_fail++;
                $display("FAIL single_press e=%0d press=%b any=%b required %b/%b", e, press_a, any_a, m, |m);
            end
            n_tests++;
            if (pressed_a[0] !== (e >= 5 && e < 11)) begin
                n_fail++;
                $display("FAIL single_level e=%0d pressed0=%b required %b", e, pressed_a[0], (e >= 5 && e < 11));
            end
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL single_missing left=%0d required 0", exp_q.size());
        end
    endtask

    task automatic test_bounce();
        logic [3:0] m;
        do_reset();
        sb_push(4'b0010, 9);
        for (int e = 0; e < 13; e++) begin
            key_a = (e == 3) ? 4'b1111 : 4'b1101;
            @(posedge clk);
            #1;
            sb_pop(e, m);
            n_tests++;
            if (press_a !== m || any_a !== (|m)) begin
                n_fail++;
                $display("FAIL bounce e=%0d press=%b any=%b required %b/%b", e, press_a, any_a, m, |m);
            end
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL bounce_missing left=%0d required 0", exp_q.size());
        end
    endtask

    task automatic test_repeat();
        logic [3:0] m;
        do_reset();
        sb_push(4'b0100, 5);
        sb_push(4'b0100, 13);
        sb_push(4'b0100, 16);
        sb_push(4'b0100, 19);
        sb_push(4'b0100, 22);
        // release sampled at 20, debounced at 25: the repeat due at 25 must not fire
        for (int e = 0; e < 36; e++) begin
            key_a = (e < 20) ? 4'b1011 : 4'b1111;
            @(posedge clk);
            #1;
            sb_pop(e, m);
            n_tests++;
            if (press_a !== m || any_a !== (|m)) begin
                n_fail++;
                $display("FAIL repeat e=%0d press=%b any=%b required %b/%b", e, press_a, any_a, m, |m);
            end
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL repeat_missing left=%0d required 0", exp_q.size());
        end
        n_tests++;
        if (state_a[5:4] !== 2'd0 || pressed_a[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL repeat_release state=%0d pressed2=%b required 0/0", state_a[5:4], pressed_a[2]);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] m;
        int any_cnt;
        any_cnt = 0;
        do_reset();
        sb_push(4'b1001, 5);
        for (int e = 0; e < 14; e++) begin
            key_a = (e < 6) ? 4'b0110 : 4'b1111;
            @(posedge clk);
            #1;
            sb_pop(e, m);
            if (any_a === 1'b1) any_cnt++;
            n_tests++;
            if (press_a !== m || any_a !== (|m)) begin
                n_fail++;
                $display("FAIL simultaneous e=%0d press=%b any=%b required %b/%b", e, press_a, any_a, m, |m);
            end
        end
        n_tests++;
        if (any_cnt != 1) begin
            n_fail++;
            $display("FAIL any_count got=%0d required 1", any_cnt);
        end
    endtask

    task automatic test_clr_mid_repeat();
        logic [3:0] m;
        logic exp_lvl;
        do_reset();
        sb_push(4'b0100, 5);
        sb_push(4'b0100, 13);
        sb_push(4'b0100, 21);
        sb_push(4'b0100, 29);
        sb_push(4'b0100, 32);
        for (int e = 0; e < 34; e++) begin
            key_a = 4'b1011;
            clr   = (e == 14 || e == 15);
            @(posedge clk);
            #1;
            sb_pop(e, m);
            exp_lvl = (e >= 5 && e < 14) || (e >= 21);
            n_tests++;
            if (press_a !== m || any_a !== (|m)) begin
                n_fail++;
                $display("FAIL clr_press e=%0d press=%b any=%b required %b/%b", e, press_a, any_a, m, |m);
            end
            n_tests++;
            if (pressed_a !== {1'b0, exp_lvl, 2'b00}) begin
                n_fail++;
                $display("FAIL clr_level e=%0d pressed=%b required %b", e, pressed_a, {1'b0, exp_lvl, 2'b00});
            end
        end
        clr = 1'b0;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL clr_missing left=%0d required 0", exp_q.size());
        end
    endtask

    task automatic test_no_repeat();
        logic [3:0] m;
        do_reset();
        sb_push(4'b1000, 5);
        for (int e = 0; e < 100; e++) begin
            key_b = 4'b0111;
            @(posedge clk);
            #1;
            sb_pop(e, m);
            n_tests++;
            if (press_b !== m || any_b !== (|m)) begin
                n_fail++;
                $display("FAIL no_repeat e=%0d press=%b any=%b required %b/%b", e, press_b, any_b, m, |m);
            end
            if (e >= 5) begin
                n_tests++;
                if (pressed_b[3] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL no_repeat_level e=%0d pressed3=%b required 1", e, pressed_b[3]);
                end
            end
        end
        n_tests++;
        if (exp_q.size() != 0 || state_b[7:6] !== 2'd1) begin
            n_fail++;
            $display("FAIL no_repeat_end left=%0d state=%0d required 0/1", exp_q.size(), state_b[7:6]);
        end
    endtask

    initial begin
        clr   = 1'b1;
        key_a = 4'hF;
        key_b = 4'hF;
        test_reset();
        test_single_press();
        test_bounce();
        test_repeat();
        test_back_to_back();
        test_clr_mid_repeat();
        test_no_repeat();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
